// File: rtl/vram_arbiter.sv
// Arbiter and access sequencer for the single asynchronous VRAM chip shared by
// the display pixel-fetch port (priority) and the host bus port.
//
// state   | meaning
// IDLE    | strobes inactive; a pending request is granted at the next edge
// ACCESS  | chip strobed; tick counter runs down to the capture edge
// RECOVER | one turnaround cycle with strobes inactive, no grant issued
module vram_arbiter #(
    parameter int address_width = 18,
    parameter int word_length   = 16,
    parameter int access_ticks  = 3,
    parameter int starve_limit  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     disp_req,
    input  logic [address_width-1:0] disp_addr,
    output logic                     disp_gnt,
    output logic                     disp_valid,
    output logic [word_length-1:0]   disp_data,
    input  logic                     host_req,
    input  logic                     host_write,
    input  logic [address_width-1:0] host_addr,
    input  logic [word_length-1:0]   host_wdata,
    output logic                     host_gnt,
    output logic                     host_valid,
    output logic [word_length-1:0]   host_rdata,
    output logic [address_width-1:0] chip_address_lines,
    inout  wire  [word_length-1:0]   chip_data_lines,
    output logic                     chip_disable,
    output logic                     write_disable,
    output logic                     byte_low_disable,
    output logic                     byte_high_disable,
    output logic                     output_disable
);

    localparam int tick_w   = (access_ticks > 1) ? $clog2(access_ticks) : 1;
    localparam int starve_w = $clog2(starve_limit + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t                 state, state_next;
    logic [tick_w-1:0]      tick_cnt;
    logic [starve_w-1:0]    starve_cnt;
    logic                   owner_host;
    logic                   is_write;
    logic [word_length-1:0] wdata;
    logic                   grant_disp, grant_host, access_done;
    logic                   host_starved;

    assign host_starved = host_req && (starve_cnt == starve_w'(starve_limit));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        grant_disp  = 1'b0;
        grant_host  = 1'b0;
        access_done = 1'b0;
        case (state)
            IDLE: begin
                if (disp_req && !host_starved) begin
                    grant_disp = 1'b1;
                    state_next = ACCESS;
                end else if (host_req) begin
                    grant_host = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (tick_cnt == '0) begin
                    access_done = 1'b1;
                    state_next  = RECOVER;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt           <= '0;
            owner_host         <= 1'b0;
            is_write           <= 1'b0;
            wdata              <= '0;
            chip_address_lines <= '0;
            chip_disable       <= 1'b1;
            write_disable      <= 1'b1;
            output_disable     <= 1'b1;
            disp_gnt           <= 1'b0;
            host_gnt           <= 1'b0;
            disp_valid         <= 1'b0;
            host_valid         <= 1'b0;
            disp_data          <= '0;
            host_rdata         <= '0;
        end else begin
            disp_gnt   <= grant_disp;
            host_gnt   <= grant_host;
            disp_valid <= access_done && !owner_host;
            host_valid <= access_done && owner_host;
            if (grant_disp || grant_host) begin
                tick_cnt           <= tick_w'(access_ticks - 1);
                owner_host         <= grant_host;
                is_write           <= grant_host && host_write;
                chip_address_lines <= grant_host ? host_addr : disp_addr;
                wdata              <= host_wdata;
                chip_disable       <= 1'b0;
                write_disable      <= !(grant_host && host_write);
                output_disable     <= grant_host && host_write;
            end else if (state == ACCESS) begin
                if (access_done) begin
                    chip_disable   <= 1'b1;
                    write_disable  <= 1'b1;
                    output_disable <= 1'b1;
                    if (!is_write) begin
                        if (owner_host) host_rdata <= chip_data_lines;
                        else            disp_data  <= chip_data_lines;
                    end
                end else begin
                    tick_cnt <= tick_cnt - 1'b1;
                end
            end
        end
    end

    // Counts display wins while the host is waiting; any idle host cycle forgives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!host_req || grant_host) begin
            starve_cnt <= '0;
        end else if (grant_disp && (starve_cnt != starve_w'(starve_limit))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign byte_low_disable  = chip_disable;
    assign byte_high_disable = chip_disable;

    // Bus is only driven while a host write owns the chip, never in IDLE/RECOVER.
    assign chip_data_lines = (state == ACCESS && owner_host && is_write) ? wdata : 'z;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance with access_ticks=3 and a small
// SRAM model, one with access_ticks=1 for back-to-back display reads.
module tb_vram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    int            checks = 0;
    int            errors = 0;

    logic          disp_req, host_req, host_write;
    logic [AW-1:0] disp_addr, host_addr;
    logic [DW-1:0] host_wdata;
    logic          disp_gnt, disp_valid, host_gnt, host_valid;
    logic [DW-1:0] disp_data, host_rdata;
    logic [AW-1:0] chip_addr;
    wire  [DW-1:0] chip_data;
    logic          chip_disable, write_disable, byte_low_disable, byte_high_disable, output_disable;

    logic          s_disp_req, s_host_req, s_host_write;
    logic [AW-1:0] s_disp_addr, s_host_addr;
    logic [DW-1:0] s_host_wdata;
    logic          s_disp_gnt, s_disp_valid, s_host_gnt, s_host_valid;
    logic [DW-1:0] s_disp_data, s_host_rdata;
    logic [AW-1:0] s_chip_addr;
    wire  [DW-1:0] s_chip_data;
    logic          s_ce, s_we, s_bl, s_bh, s_oe;

    always #5 clk = ~clk;

    vram_arbiter #(.address_width(AW), .word_length(DW), .access_ticks(3), .starve_limit(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_valid(host_valid),
        .host_rdata(host_rdata), .chip_address_lines(chip_addr), .chip_data_lines(chip_data),
        .chip_disable(chip_disable), .write_disable(write_disable),
        .byte_low_disable(byte_low_disable), .byte_high_disable(byte_high_disable),
        .output_disable(output_disable)
    );

    vram_arbiter #(.address_width(AW), .word_length(DW), .access_ticks(1), .starve_limit(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .disp_req(s_disp_req), .disp_addr(s_disp_addr), .disp_gnt(s_disp_gnt),
        .disp_valid(s_disp_valid), .disp_data(s_disp_data),
        .host_req(s_host_req), .host_write(s_host_write), .host_addr(s_host_addr),
        .host_wdata(s_host_wdata), .host_gnt(s_host_gnt), .host_valid(s_host_valid),
        .host_rdata(s_host_rdata), .chip_address_lines(s_chip_addr), .chip_data_lines(s_chip_data),
        .chip_disable(s_ce), .write_disable(s_we),
        .byte_low_disable(s_bl), .byte_high_disable(s_bh), .output_disable(s_oe)
    );

    // SRAM model: 64 words indexed by the low address bits, read combinationally.
    logic [DW-1:0] mem [0:63];
    logic          mem_loaded = 1'b0;

    assign chip_data = (!chip_disable && !output_disable && write_disable) ? mem[chip_addr[5:0]] : 'z;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[16]    <= 16'hA5C3;
            mem_loaded <= 1'b1;
        end else if (!chip_disable && !write_disable) begin
            mem[chip_addr[5:0]] <= chip_data;
        end
    end

    assign s_chip_data = (!s_ce && !s_oe && s_we) ? (s_chip_addr[15:0] ^ 16'h5A5A) : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int        gcyc[$];
    bit        gown[$];
    int        cyc;
    int        both;
    int        vcnt, vcyc;
    bit        dropped;
    logic [9:0] exp3;
    logic [7:0] exp4;

    initial begin
        reset_n    = 1'b0;
        disp_req   = 1'b0; disp_addr = '0;
        host_req   = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
        s_disp_req = 1'b0; s_disp_addr = '0;
        s_host_req = 1'b0; s_host_write = 1'b0; s_host_addr = '0; s_host_wdata = '0;
        exp3 = 10'b1000010000;
        exp4 = 8'b10000000;

        #12;
        chk("rst_chip_disable", 32'(chip_disable), 32'd1);
        chk("rst_write_disable", 32'(write_disable), 32'd1);
        chk("rst_output_disable", 32'(output_disable), 32'd1);
        chk("rst_byte_disables", 32'({byte_low_disable, byte_high_disable}), 32'd3);
        chk("rst_addr", 32'(chip_addr), 32'd0);
        chk("rst_gnt_valid", 32'({disp_gnt, host_gnt, disp_valid, host_valid}), 32'd0);
        chk("rst_data", 32'({disp_data, host_rdata}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single display read
        disp_req = 1'b1; disp_addr = 18'h00010;
        step;
        chk("rd_gnt", 32'(disp_gnt), 32'd1);
        chk("rd_strobes", 32'({chip_disable, write_disable, output_disable}), 32'b010);
        chk("rd_addr", 32'(chip_addr), 32'h00010);
        disp_req = 1'b0; disp_addr = 18'h00003;
        step;
        chk("rd_gnt_pulse", 32'(disp_gnt), 32'd0);
        chk("rd_addr_held", 32'(chip_addr), 32'h00010);
        step;
        chk("rd_oe_mid", 32'(output_disable), 32'd0);
        chk("rd_no_early_valid", 32'(disp_valid), 32'd0);
        step;
        chk("rd_valid", 32'(disp_valid), 32'd1);
        chk("rd_data", 32'(disp_data), 32'hA5C3);
        chk("rd_strobes_off", 32'({chip_disable, write_disable, output_disable}), 32'b111);
        disp_req = 1'b1; disp_addr = 18'h00010;
        step;
        chk("rd_recover_no_gnt", 32'(disp_gnt), 32'd0);
        chk("rd_valid_pulse", 32'(disp_valid), 32'd0);
        step;
        chk("rd_next_gnt", 32'(disp_gnt), 32'd1);
        disp_req = 1'b0;
        repeat (3) step;
        chk("rd2_valid", 32'(disp_valid), 32'd1);
        repeat (2) step;

        // Host write then readback
        host_req = 1'b1; host_write = 1'b1; host_addr = 18'h3FFFF; host_wdata = 16'h1234;
        step;
        chk("wr_gnt", 32'(host_gnt), 32'd1);
        chk("wr_strobes", 32'({chip_disable, write_disable, output_disable}), 32'b001);
        chk("wr_bus", 32'(chip_data), 32'h1234);
        chk("wr_addr", 32'(chip_addr), 32'h3FFFF);
        host_req = 1'b0; host_wdata = 16'hFFFF;
        step;
        chk("wr_bus_held", 32'(chip_data), 32'h1234);
        step;
        step;
        chk("wr_valid", 32'(host_valid), 32'd1);
        chk("wr_bus_released", 32'(chip_data !== 16'h1234), 32'd1);
        chk("wr_rdata_unchanged", 32'(host_rdata), 32'd0);
        step;
        chk("wr_valid_pulse", 32'(host_valid), 32'd0);
        host_req = 1'b1; host_write = 1'b0;
        step;
        chk("rb_gnt", 32'(host_gnt), 32'd1);
        host_req = 1'b0;
        repeat (3) step;
        chk("rb_valid", 32'(host_valid), 32'd1);
        chk("rb_data", 32'(host_rdata), 32'h1234);
        chk("rb_disp_data_held", 32'(disp_data), 32'hA5C3);
        step;

        // Both held continuously: starvation guard
        disp_req = 1'b1; host_req = 1'b1; host_write = 1'b0;
        disp_addr = 18'h00010; host_addr = 18'h3FFFF;
        cyc = 0; both = 0;
        while (gcyc.size() < 10 && cyc < 200) begin
            step; cyc++;
            if (disp_gnt && host_gnt) both++;
            if (disp_gnt) begin gcyc.push_back(cyc); gown.push_back(1'b0); end
            else if (host_gnt) begin gcyc.push_back(cyc); gown.push_back(1'b1); end
        end
        disp_req = 1'b0; host_req = 1'b0;
        chk("starve_count", 32'(gcyc.size()), 32'd10);
        chk("starve_no_double", 32'(both), 32'd0);
        for (int i = 0; i < gcyc.size(); i++) begin
            chk($sformatf("starve_owner%0d", i), 32'(gown[i]), 32'(exp3[i]));
            if (i > 0) chk($sformatf("starve_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd5);
        end
        repeat (6) step;

        // Host drops for one cycle after 3 display grants
        gcyc.delete(); gown.delete();
        disp_req = 1'b1; host_req = 1'b1;
        cyc = 0; dropped = 1'b0;
        while (gcyc.size() < 8 && cyc < 200) begin
            step; cyc++;
            if (disp_gnt) begin gcyc.push_back(cyc); gown.push_back(1'b0); end
            else if (host_gnt) begin gcyc.push_back(cyc); gown.push_back(1'b1); end
            if (dropped && !host_req) host_req = 1'b1;
            else if (gcyc.size() == 3 && !dropped) begin host_req = 1'b0; dropped = 1'b1; end
        end
        disp_req = 1'b0; host_req = 1'b0;
        chk("clear_count", 32'(gcyc.size()), 32'd8);
        for (int i = 0; i < gcyc.size(); i++)
            chk($sformatf("clear_owner%0d", i), 32'(gown[i]), 32'(exp4[i]));
        repeat (6) step;

        // Reset in the middle of a host write
        host_req = 1'b1; host_write = 1'b1; host_addr = 18'h3FFFF; host_wdata = 16'hBEEF;
        step;
        chk("rstw_gnt", 32'(host_gnt), 32'd1);
        step;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstw_strobes", 32'({chip_disable, write_disable, byte_low_disable, byte_high_disable, output_disable}), 32'b11111);
        chk("rstw_addr", 32'(chip_addr), 32'd0);
        chk("rstw_bus_released", 32'(chip_data !== 16'hBEEF), 32'd1);
        vcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (host_valid) vcnt++;
        end
        reset_n = 1'b1;
        step;
        chk("rstw_first_edge_gnt", 32'(host_gnt), 32'd1);
        host_req = 1'b0;
        vcyc = 0;
        for (int i = 1; i <= 5; i++) begin
            step;
            if (host_valid) begin vcnt++; vcyc = i; end
        end
        chk("rstw_valid_count", 32'(vcnt), 32'd1);
        chk("rstw_valid_cycle", 32'(vcyc), 32'd3);

        // access_ticks=1 back-to-back display reads
        gcyc.delete();
        s_disp_req = 1'b1; s_disp_addr = 18'h00123;
        both = 0; vcyc = 0;
        for (int i = 1; i <= 10; i++) begin
            step;
            if (s_disp_gnt) gcyc.push_back(i);
            if (s_disp_valid && vcyc == 0) vcyc = i;
            if (s_disp_gnt && s_disp_valid) both++;
            if (i == 2) chk("t1_data", 32'(s_disp_data), 32'h5B79);
        end
        s_disp_req = 1'b0;
        chk("t1_gnt_count", 32'(gcyc.size()), 32'd4);
        chk("t1_first_gnt", 32'(gcyc.size() > 0 ? gcyc[0] : -1), 32'd1);
        chk("t1_valid_lat", 32'(vcyc), 32'd2);
        chk("t1_gap", 32'(gcyc.size() > 1 ? gcyc[1] - gcyc[0] : -1), 32'd3);
        chk("t1_no_overlap", 32'(both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
